shft_sub_div: RTL and testbench
===============================

// Module: shft_sub_div
// PURPOSE
//   Sequential restoring divider: unsigned W-bit dividend / W-bit divisor -> quotient + remainder,
//   one quotient bit per clock, MSB first. Inverse of the sequential add-shift multiplier; same
//   start/done handshake, so both share one arithmetic controller and one bench.
// PARAMETERS
//   W     8   operand width (dividend, divisor, quotient, remainder); legal range 2..32
// PORTS
//   clk     in   1  clock; all state updates on rising edge
//   rst     in   1  reset, asynchronous, active-low (asserted when 0); release is synchronised upstream
//   a       in   W  dividend, sampled only on a start cycle
//   b       in   W  divisor, sampled only on a start cycle
//   start   in   1  single-cycle pulse; launches a division
//   q       out  W  quotient (register)
//   r       out  W  remainder (register)
//   done    out  1  level: 1 when idle/result valid, 0 while busy
//   dbz     out  1  divide-by-zero flag for the current/last operation (register)
// BEHAVIOUR
//   - Reset (rst=0, any time, asynchronous): cnt<=W, q<=0, r<=0, dbz<=0, internal operands 0;
//     done=1 immediately. Operation in flight is abandoned; no partial result is kept.
//   - State: cnt in 0..W (width $clog2(W+1)); busy = (cnt!=W); done = !busy (combinational).
//   - Start cycle (start=1, rst=1): latch dvd<=a, dvs<=b, q<=0, r<=0, dbz<=(b==0), cnt<=0.
//     Start has priority over iteration: start while busy aborts and restarts with new operands.
//   - Iteration (busy, no start), step k=cnt (0..W-1), bit i=W-1-k:
//       t = {r, dvd[i]} (W+1 bits); if t >= {1'b0,dvs}: r<=t-dvs, q[i]<=1 else r<=t[W-1:0], q[i]<=0;
//       cnt<=cnt+1. Subtraction done in W+1 bits; remainder always fits W bits.
//   - Latency: start at edge E0 -> done rises after edge E0+W (exactly W busy cycles); q, r valid
//     and stable from that point until the next start or reset. Idle: q, r, dbz held.
//   - a, b may change freely after the start cycle without affecting the result.
//   - Divide by zero: no special path; algorithm yields q={W{1'b1}}, r=a in W cycles, dbz=1.
//   - b > a: q=0, r=a. b==1: q=a, r=0. a==0: q=0, r=0 (dbz per b).
//   - start held high for multiple cycles: each cycle restarts; computation begins on the last one.
//   - Invariant on done: q*b + r == a and r < b (b!=0).
// STRUCTURE
//   - Shared arithmetic package: default width constant ARITH_W=8 used by multiplier and divider,
//     plus handshake doc constants; no typedefs needed beyond W-bit vectors.
//   - One natural sub-module: shft_sub_step (combinational, W param): inputs r, dvd bit, dvs;
//     outputs next r and quotient bit. Controller (counter, start/done, registers) stays here.
//   - No FSM enum: counter value is the state (IDLE = cnt==W, RUN = cnt<W).
// TESTING
//   - Reset/idle: hold rst=0 then release -> done=1, q=0, r=0, dbz=0; no start -> no change.
//   - Basic: a=100, b=7, start pulse -> done rises exactly 8 cycles later, q=14, r=2, dbz=0.
//   - Boundaries: 255/1 -> q=255, r=0; 3/200 -> q=0, r=3; 255/255 -> q=1, r=0; 0/9 -> q=0, r=0.
//   - Divide by zero: a=5, b=0 -> after 8 cycles q=255, r=5, dbz=1; next 10/3 -> dbz=0, q=3, r=1.
//   - Restart/abort: start 200/3, after 3 cycles start 65/4 -> done 8 cycles after 2nd start,
//     q=16, r=1; drive rst=0 mid-op -> done=1, q=r=0 asynchronously (before next edge).
//   - Random + cross-check: 1000 random a,b (b!=0), a/b changed after start; check q*b+r==a,
//     r<b, latency W; feed q,b through add_shft_mul and compare product+r with a.

Source files
------------

// File: rtl/shft_sub_div_pkg.sv
// shft_sub_div_pkg: arithmetic constants shared by the sequential multiplier and divider.
package shft_sub_div_pkg;
    localparam int ARITH_W = 8;
    // done is a level: high when idle/result valid, low while iterating
    localparam logic DONE_IDLE = 1'b1;
    localparam logic DONE_BUSY = 1'b0;
endpackage

// File: rtl/shft_sub_div_step.sv
// shft_sub_div_step: one restoring-division step (shift in a dividend bit, trial subtract).
module shft_sub_div_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] r,
    input  logic         din,
    input  logic [W-1:0] dvs,
    output logic [W-1:0] r_nxt,
    output logic         q_bit
);
    logic [W:0] t;

    always_comb begin
        t     = {r, din};
        q_bit = t >= {1'b0, dvs};
        r_nxt = q_bit ? W'(t - {1'b0, dvs}) : t[W-1:0];
    end
endmodule

// File: rtl/shft_sub_div.sv
// shft_sub_div: sequential restoring divider, one quotient bit per clock, MSB first.
module shft_sub_div
    import shft_sub_div_pkg::*;
#(
    parameter int W = ARITH_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         start,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         done,
    output logic         dbz
);
    localparam int CW = $clog2(W + 1);

    logic [CW-1:0] cnt;
    logic [W-1:0]  dvd, dvs, r_nxt;
    logic          q_bit;

    shft_sub_div_step #(.W(W)) u_step (
        .r     (r),
        .din   (dvd[W-1]),
        .dvs   (dvs),
        .r_nxt (r_nxt),
        .q_bit (q_bit)
    );

    assign done = (cnt == CW'(W)) ? DONE_IDLE : DONE_BUSY;

    // The dividend shifts left so its next bit is always at the MSB; q fills from the LSB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= CW'(W);
            dvd <= '0;
            dvs <= '0;
            q   <= '0;
            r   <= '0;
            dbz <= 1'b0;
        end else if (start) begin
            cnt <= '0;
            dvd <= a;
            dvs <= b;
            q   <= '0;
            r   <= '0;
            dbz <= (b == '0);
        end else if (cnt != CW'(W)) begin
            cnt <= cnt + CW'(1);
            dvd <= {dvd[W-2:0], 1'b0};
            q   <= {q[W-2:0], q_bit};
            r   <= r_nxt;
        end
    end
endmodule

// File: tb/tb_shft_sub_div.sv
// tb_shft_sub_div: directed and random checks of shft_sub_div against a quotient/remainder model.
module tb_shft_sub_div;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         start = 1'b0;
    logic [W-1:0] q, r;
    logic         done, dbz;

    int n_cmp = 0;
    int n_bad = 0;

    shft_sub_div #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .start (start),
        .q     (q),
        .r     (r),
        .done  (done),
        .dbz   (dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: the result is known the moment the operands are latched; only the wait is modelled.
    int           m_wait = 0;
    logic [W-1:0] m_q = '0, m_r = '0;
    logic         m_dbz = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_wait = 0; m_q = '0; m_r = '0; m_dbz = 1'b0;
        end else if (start) begin
            m_wait = W;
            m_dbz  = (b == 0);
            m_q    = (b == 0) ? {W{1'b1}} : a / b;
            m_r    = (b == 0) ? a : a % b;
        end else if (m_wait > 0) begin
            m_wait = m_wait - 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_done", done, 1);
            chk("rst_q", q, 0);
            chk("rst_r", r, 0);
        end else begin
            chk("done", done, m_wait == 0);
            chk("dbz", dbz, m_dbz);
            if (m_wait == 0) begin
                chk("q", q, m_q);
                chk("r", r, m_r);
            end
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < W + 4) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic launch(input logic [W-1:0] da, input logic [W-1:0] db);
        @(negedge clk);
        a = da; b = db; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
    endtask

    task automatic run(input logic [W-1:0] da, input logic [W-1:0] db,
                       input int eq, input int er, input int edbz);
        int n;
        launch(da, db);
        wait_done(n);
        chk("latency", n, W);
        chk("lit_q", q, eq);
        chk("lit_r", r, er);
        chk("lit_dbz", dbz, edbz);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset_done", done, 1);
        chk("reset_q", q, 0);
        chk("reset_dbz", dbz, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_done", done, 1);
        chk("idle_r", r, 0);

        run(100, 7, 14, 2, 0);
        run(255, 1, 255, 0, 0);
        run(3, 200, 0, 3, 0);
        run(255, 255, 1, 0, 0);
        run(0, 9, 0, 0, 0);
        run(5, 0, 255, 5, 1);
        run(10, 3, 3, 1, 0);
        repeat (3) @(negedge clk);
        chk("hold_q", q, 3);

        launch(200, 3);
        repeat (2) @(negedge clk);
        launch(65, 4);
        wait_done(n);
        chk("restart_latency", n, W);
        chk("restart_q", q, 16);
        chk("restart_r", r, 1);

        @(negedge clk);
        a = 50; b = 6; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        a = 77; b = 5;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("multi_start_q", q, 15);
        chk("multi_start_r", r, 2);

        launch(200, 3);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_done", done, 1);
        chk("async_q", q, 0);
        chk("async_r", r, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom_range(1, (1 << W) - 1));
            launch(ra, rb);
            wait_done(n);
            chk("rand_latency", n, W);
            chk("rand_identity", int'(q) * int'(rb) + int'(r), int'(ra));
            chk("rand_r_lt_b", int'(r < rb), 1);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
